// File: rtl/match_window_counter_if.sv
// match_window_counter_if: control, match input and result handshake bundle
interface match_window_counter_if #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
);
  logic             start;
  logic [WIN_W-1:0] win_len;
  logic             z;
  logic             busy;
  logic [CNT_W-1:0] cnt_out;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  modport master (
    output start, win_len, z, out_ready,
    input  busy, cnt_out, sat, out_valid
  );
  modport slave (
    input  start, win_len, z, out_ready,
    output busy, cnt_out, sat, out_valid
  );
endinterface

// File: rtl/match_window_counter.sv
// match_window_counter: counts z pulses over a W-cycle window and reports the saturated count
module match_window_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input logic clk,
  input logic rst,
  match_window_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COUNT, REPORT} state_t;
  state_t state, next_state;
  logic [WIN_W-1:0] last, timer;
  logic [CNT_W-1:0] count, count_next, cnt_q;
  logic flag, flag_next, sat_q, valid_q, done;
  // timer compares against W-1, so W = 2^WIN_W-1 never needs the timer to wrap
  assign done = timer == last;
  // next count/saturation flag for the current z sample
  always_comb begin
    count_next = bus.z && !(&count) ? count + 1'b1 : count;
    flag_next = flag | (bus.z & (&count));
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= next_state;
  end
  // next-state logic
  always_comb begin
    next_state = state == IDLE ? (bus.start ? COUNT : IDLE) :
                 state == COUNT ? (done ? REPORT : COUNT) :
                 state == REPORT && !bus.out_ready ? REPORT : IDLE;
  end
  // window datapath and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= '0;
      timer <= '0;
      count <= '0;
      flag <= 1'b0;
      cnt_q <= '0;
      sat_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      last <= bus.win_len == '0 ? '0 : bus.win_len - 1'b1;
      timer <= '0;
      count <= '0;
      flag <= 1'b0;
    end else if (state == COUNT) begin
      count <= count_next;
      flag <= flag_next;
      timer <= timer + 1'b1;
      if (done) begin
        cnt_q <= count_next;
        sat_q <= flag_next;
        valid_q <= 1'b1;
      end
    end else if (state == REPORT && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end
  // outputs decoded from registers only
  always_comb begin
    bus.busy = state != IDLE;
    bus.cnt_out = cnt_q;
    bus.sat = sat_q;
    bus.out_valid = valid_q;
  end
endmodule

// File: tb/tb_match_window_counter.sv
// tb_match_window_counter: directed windows with a result scoreboard checked on handshake
module tb_match_window_counter;
  typedef struct packed {logic [7:0] cnt; logic sat;} res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  res_t q[$];
  match_window_counter_if bus ();
  match_window_counter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // scoreboard monitor: pops one expected result per accepted output
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        res_t e;
        e = q.pop_front();
        chk("cnt_out", 32'(bus.cnt_out), 32'(e.cnt));
        chk("sat", 32'(bus.sat), 32'(e.sat));
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  // E0 through EW; win_len and start are scrambled during COUNT and must be ignored
  task automatic feed(input int wl, input bit all1, input logic [31:0] mask);
    int n;
    n = wl == 0 ? 1 : wl;
    bus.start = 1'b1;
    bus.win_len = 16'(wl);
    tick();
    chk("valid_after_e0", 32'(bus.out_valid), 0);
    chk("busy_after_e0", 32'(bus.busy), 1);
    for (int i = 1; i <= n; i++) begin
      bus.z = all1 ? 1'b1 : (i <= 32 ? mask[i-1] : 1'b0);
      bus.win_len = 16'(~wl);
      bus.start = i[0];
      if (i == n) chk("valid_before_ew", 32'(bus.out_valid), 0);
      tick();
    end
    bus.z = 1'b0;
    bus.start = 1'b0;
    chk("valid_after_ew", 32'(bus.out_valid), 1);
    chk("busy_in_report", 32'(bus.busy), 1);
  endtask
  task automatic run(input int wl, input bit all1, input logic [31:0] mask,
                     input logic [7:0] ecnt, input logic esat);
    q.push_back('{cnt: ecnt, sat: esat});
    feed(wl, all1, mask);
    tick();
    chk("valid_after_hs", 32'(bus.out_valid), 0);
    chk("busy_after_hs", 32'(bus.busy), 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.win_len = '0;
    bus.z = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_cnt", 32'(bus.cnt_out), 0);
    chk("rst_sat", 32'(bus.sat), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    tick();
    chk("idle_busy", 32'(bus.busy), 0);
    // basic: samples 1,3,4,8 high
    run(8, 1'b0, 32'h8D, 8'd4, 1'b0);
    // async reset mid-window
    bus.start = 1'b1;
    bus.win_len = 16'd8;
    bus.z = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_cnt", 32'(bus.cnt_out), 0);
    chk("midrst_sat", 32'(bus.sat), 0);
    chk("midrst_valid", 32'(bus.out_valid), 0);
    #3 rst = 1'b0;
    bus.z = 1'b0;
    tick();
    chk("post_rst_busy", 32'(bus.busy), 0);
    tick();
    chk("post_rst_busy2", 32'(bus.busy), 0);
    // saturation then clean window
    run(300, 1'b1, 32'h0, 8'd255, 1'b1);
    run(300, 1'b0, 32'h0, 8'd0, 1'b0);
    // boundary lengths
    run(0, 1'b1, 32'h0, 8'd1, 1'b0);
    run(1, 1'b0, 32'h1, 8'd1, 1'b0);
    run(1, 1'b0, 32'h0, 8'd0, 1'b0);
    run(5, 1'b0, 32'h15, 8'd3, 1'b0);
    // backpressure
    bus.out_ready = 1'b0;
    q.push_back('{cnt: 8'd4, sat: 1'b0});
    feed(4, 1'b1, 32'h0);
    for (int i = 0; i < 10; i++) begin
      bus.z = i[0];
      bus.start = ~i[0];
      tick();
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_busy", 32'(bus.busy), 1);
      chk("bp_cnt", 32'(bus.cnt_out), 4);
    end
    bus.start = 1'b0;
    bus.z = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_hs_valid", 32'(bus.out_valid), 0);
    chk("bp_hs_busy", 32'(bus.busy), 0);
    tick();
    chk("bp_no_restart", 32'(bus.busy), 0);
    // back-to-back windows with start held high, z high throughout
    repeat (3) q.push_back('{cnt: 8'd3, sat: 1'b0});
    bus.win_len = 16'd3;
    bus.z = 1'b1;
    bus.start = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("b2b_valid", 32'(bus.out_valid), 32'(i % 5 == 4));
      if (i == 15) bus.start = 1'b0;
    end
    bus.z = 1'b0;
    repeat (3) tick();
    chk("b2b_idle", 32'(bus.busy), 0);
    chk("queue_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
